// File: rtl/demux2way32_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux2way32_stream
// Description : 1-to-2 router for 32-bit words. Each accepted word is queued
//               into the FIFO of output A (sel=0) or output B (sel=1), so a
//               stalled consumer on one side never blocks the other side.
// Revision    : 1.0 - initial release
// ============================================================================
module demux2way32_stream #(
    parameter int DEPTH = 2,   // entries per output FIFO, power of two, >= 2
    parameter int LVLW  = 2    // level width, must hold the value DEPTH
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_sel,
    output logic            a_valid,
    input  logic            a_ready,
    output logic [31:0]     a_data,
    output logic [LVLW-1:0] a_level,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [31:0]     b_data,
    output logic [LVLW-1:0] b_level
);

    localparam int              c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVLW-1:0] c_FULL  = LVLW'(DEPTH);

    // Per-channel views: index 0 is output A, index 1 is output B.
    logic [1:0]      w_sink_ready;
    logic [1:0]      w_not_full;
    logic [1:0]      w_valid;
    logic [31:0]     w_head  [2];
    logic [LVLW-1:0] w_level [2];

    assign w_sink_ready = {b_ready, a_ready};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        localparam logic c_SEL = (ch == 1);

        logic [31:0]        r_mem [DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [LVLW-1:0]    r_level;
        logic               w_push;
        logic               w_pop;

        // Fullness looks only at the registered level: a pop in the same
        // cycle does not open a slot, which keeps in_ready free of any path
        // from the sink-side ready inputs.
        assign w_not_full[ch] = (r_level != c_FULL);
        assign w_valid[ch]    = (r_level != '0);
        assign w_push         = in_valid && (in_sel == c_SEL) && w_not_full[ch];
        assign w_pop          = w_valid[ch] && w_sink_ready[ch];
        // Head is forced to zero while empty so stale storage never leaks out.
        assign w_head[ch]     = w_valid[ch] ? r_mem[r_rptr] : '0;
        assign w_level[ch]    = r_level;

        // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end
        end

        // Word storage; contents need no reset because the head is masked
        // whenever the level is zero.
        always_ff @(posedge clk) begin
            if (reset_n && w_push) begin
                r_mem[r_wptr] <= in_data;
            end
        end
    end

    assign in_ready = in_sel ? w_not_full[1] : w_not_full[0];

    assign a_valid  = w_valid[0];
    assign a_data   = w_head[0];
    assign a_level  = w_level[0];
    assign b_valid  = w_valid[1];
    assign b_data   = w_head[1];
    assign b_level  = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2way32_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux2way32_stream
// Description : Self-checking bench for demux2way32_stream, compared against
//               a queue-based reference of the two output FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux2way32_stream;

    localparam int DEPTH = 2;
    localparam int LVLW  = 2;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_sel   = 1'b0;
    logic [31:0]     in_data  = '0;
    logic            a_ready  = 1'b0;
    logic            b_ready  = 1'b0;
    logic            in_ready;
    logic            a_valid;
    logic            b_valid;
    logic [31:0]     a_data;
    logic [31:0]     b_data;
    logic [LVLW-1:0] a_level;
    logic [LVLW-1:0] b_level;

    int total = 0;
    int bad   = 0;

    // Reference: each output FIFO is simply a queue of words.
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    logic [69:0] obs;

    demux2way32_stream #(.DEPTH(DEPTH), .LVLW(LVLW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_level  (a_level),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_level  (b_level)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Every observable output packed into one vector for whole-state compares.
    always_comb obs = {a_valid, a_data, a_level, b_valid, b_data, b_level};

    function automatic logic [69:0] exp_state();
        logic [31:0] ha;
        logic [31:0] hb;
        ha = (qa.size() != 0) ? qa[0] : 32'd0;
        hb = (qb.size() != 0) ? qb[0] : 32'd0;
        return {qa.size() != 0, ha, LVLW'(qa.size()),
                qb.size() != 0, hb, LVLW'(qb.size())};
    endfunction

    function automatic logic exp_ready();
        return in_sel ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
    endfunction

    // Advance one clock edge and apply the same edge to the reference queues.
    task automatic tick();
        bit          do_push;
        bit          pop_a;
        bit          pop_b;
        bit          rst;
        logic        sel;
        logic [31:0] d;
        do_push = in_valid && exp_ready();
        sel     = in_sel;
        d       = in_data;
        pop_a   = (qa.size() != 0) && a_ready;
        pop_b   = (qb.size() != 0) && b_ready;
        rst     = !reset_n;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pop_a) void'(qa.pop_front());
            if (pop_b) void'(qb.pop_front());
            if (do_push) begin
                if (sel) qb.push_back(d);
                else     qa.push_back(d);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        repeat (2) tick();
        total++;
        if (obs !== 70'd0) begin
            bad++;
            $display("FAIL reset_zero: got %h want 0", obs);
        end
        total++;
        if (obs !== exp_state()) begin
            bad++;
            $display("FAIL reset_model: got %h want %h", obs, exp_state());
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_routing();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hDEADBEEF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL route_ready: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({a_valid, a_data, b_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("FAIL route_a: got v=%b d=%h bv=%b want v=1 d=deadbeef bv=0", a_valid, a_data, b_valid);
        end
        in_sel  = 1'b1;
        in_data = 32'h12345678;
        tick();
        total++;
        if ({b_valid, b_data, a_valid} !== {1'b1, 32'h12345678, 1'b0}) begin
            bad++;
            $display("FAIL route_b: got v=%b d=%h av=%b want v=1 d=12345678 av=0", b_valid, b_data, a_valid);
        end
        total++;
        if (obs !== exp_state()) begin
            bad++;
            $display("FAIL route_model: got %h want %h", obs, exp_state());
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (obs !== 70'd0) begin
            bad++;
            $display("FAIL route_drained: got %h want 0", obs);
        end
    endtask

    task automatic test_full();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h1;
        tick();
        in_data  = 32'h2;
        tick();
        total++;
        if (a_level !== 2'd2) begin
            bad++;
            $display("FAIL full_level: got %0d want 2", a_level);
        end
        in_data = 32'h99;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready_a: got %b want 0", in_ready);
        end
        in_sel  = 1'b1;
        in_data = 32'h3;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_ready_b: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({b_valid, b_data, b_level, a_level} !== {1'b1, 32'h3, 2'd1, 2'd2}) begin
            bad++;
            $display("FAIL full_push_b: got bv=%b bd=%h bl=%0d al=%0d want 1 3 1 2", b_valid, b_data, b_level, a_level);
        end
        in_valid = 1'b0;
        a_ready  = 1'b1;
        #1;
        total++;
        if ({a_valid, a_data} !== {1'b1, 32'h1}) begin
            bad++;
            $display("FAIL full_head1: got v=%b d=%h want v=1 d=1", a_valid, a_data);
        end
        tick();
        total++;
        if ({a_valid, a_data, a_level} !== {1'b1, 32'h2, 2'd1}) begin
            bad++;
            $display("FAIL full_head2: got v=%b d=%h l=%0d want v=1 d=2 l=1", a_valid, a_data, a_level);
        end
        tick();
        total++;
        if (a_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_empty_a: got %b want 0", a_valid);
        end
        b_ready = 1'b1;
        tick();
        total++;
        if (obs !== exp_state()) begin
            bad++;
            $display("FAIL full_model: got %h want %h", obs, exp_state());
        end
        b_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [31:0] w1;
        logic [31:0] d;
        a_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = $urandom;
        tick();
        w1       = $urandom;
        in_data  = w1;
        tick();
        d        = $urandom;
        in_data  = d;
        a_ready  = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_ready0: got %b want 0", in_ready);
        end
        tick();
        total++;
        if ({a_valid, a_data, a_level} !== {1'b1, w1, 2'd1}) begin
            bad++;
            $display("FAIL fullpop_nopush: got v=%b d=%h l=%0d want v=1 d=%h l=1", a_valid, a_data, a_level, w1);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL fullpop_ready1: got %b want 1", in_ready);
        end
        tick();
        total++;
        if ({a_valid, a_data, a_level} !== {1'b1, d, 2'd1}) begin
            bad++;
            $display("FAIL fullpop_swap: got v=%b d=%h l=%0d want v=1 d=%h l=1", a_valid, a_data, a_level, d);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (obs !== exp_state()) begin
            bad++;
            $display("FAIL fullpop_model: got %h want %h", obs, exp_state());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int          idx;
        int          cycles;
        bit          acc;
        bit          ok;
        idx    = 0;
        cycles = 0;
        while (got.size() < 10 && cycles < 300) begin
            in_valid = (idx < 10);
            in_sel   = 1'b1;
            in_data  = 32'h10 + idx;
            b_ready  = 1'($urandom_range(0, 1));
            a_ready  = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (in_ready !== exp_ready()) begin
                bad++;
                $display("FAIL wrap_ready: got %b want %b", in_ready, exp_ready());
            end
            if (b_valid && b_ready) got.push_back(b_data);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            cycles++;
            total++;
            if (obs !== exp_state()) begin
                bad++;
                $display("FAIL wrap_state: got %h want %h", obs, exp_state());
            end
            total++;
            if (a_valid !== 1'b0) begin
                bad++;
                $display("FAIL wrap_a_idle: got %b want 0", a_valid);
            end
        end
        in_valid = 1'b0;
        total++;
        if (got.size() != 10) begin
            bad++;
            $display("FAIL wrap_count: got %0d words want 10 (cycles=%0d)", got.size(), cycles);
        end
        ok = (got.size() == 10);
        foreach (got[i]) if (got[i] !== 32'h10 + i) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wrap_order: got %p want 0x10..0x19", got);
        end
    endtask

    task automatic test_random();
        bit acc;
        in_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (in_ready !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready: cyc %0d got %b want %b", n, in_ready, exp_ready());
            end
            acc = in_valid && in_ready;
            tick();
            total++;
            if (obs !== exp_state()) begin
                bad++;
                $display("FAIL rand_state: cyc %0d got %h want %h", n, obs, exp_state());
            end
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_midreset();
        logic [31:0] d;
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        repeat (3) tick();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = $urandom;
        tick();
        in_data  = $urandom;
        tick();
        in_sel   = 1'b1;
        in_data  = $urandom;
        tick();
        total++;
        if ({a_level, b_level} !== {2'd2, 2'd1}) begin
            bad++;
            $display("FAIL midrst_fill: got al=%0d bl=%0d want 2 1", a_level, b_level);
        end
        reset_n = 1'b0;
        tick();
        total++;
        if (obs !== 70'd0) begin
            bad++;
            $display("FAIL midrst_zero: got %h want 0", obs);
        end
        reset_n = 1'b1;
        in_sel  = 1'b0;
        d       = $urandom;
        in_data = d;
        tick();
        total++;
        if ({a_valid, a_data, a_level, b_valid} !== {1'b1, d, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL midrst_push: got v=%b d=%h l=%0d bv=%b want 1 %h 1 0", a_valid, a_data, a_level, b_valid, d);
        end
        total++;
        if (obs !== exp_state()) begin
            bad++;
            $display("FAIL midrst_model: got %h want %h", obs, exp_state());
        end
        in_valid = 1'b0;
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_routing();
        test_full();
        test_full_pop();
        test_wrap();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a run that never reaches the summary.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
